control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//   Multi-cycle fetch/decode/execute sequencer driving the 8x8 register bank's rx/ry selectors and read/write strobes.
//   Fetches 16-bit instructions over a req/valid handshake, steers the ALU and the bank input mux, and keeps PC and flags.
//   Sits directly upstream of register_bank; the bank's in_data mux (ALU/IMM/BUS) is external and driven by data_sel.
// PARAMETERS
//   PC_W    8   program counter width; PC wraps modulo 2**PC_W
//   INSTR_W 16  instruction width; fixed format below, other values unsupported
// PORTS
//   clk           in   1        system clock, rising edge
//   rst_n         in   1        asynchronous active-low reset
//   instr_req     out  1        fetch request, held high in FETCH until instr_valid
//   pc_out        out  PC_W     fetch address, valid while instr_req=1
//   instr_valid   in   1        instruction word valid this cycle (ignored outside FETCH)
//   instr_in      in   INSTR_W  instruction word
//   rx_sel        out  3        destination / ALU operand A register select
//   ry_sel        out  3        ALU operand B / bus-read register select
//   reg_read_en   out  1        bank drives ry onto bus (MOV only)
//   reg_write_en  out  1        one-cycle write strobe to bank register rx_sel
//   data_sel      out  2        bank input source: 00 ALU, 01 IMM, 10 BUS
//   imm_out       out  8        instr[7:0] of current instruction
//   alu_op        out  3        000 ADD 001 SUB 010 AND 011 OR 100 XOR
//   alu_flags_in  in   4        {Z,N,C,V} from ALU, sampled at end of EXECUTE
//   halted        out  1        high in HALT state
//   illegal_op    out  1        sticky illegal-opcode indicator (see CONFIGURATION)
// BEHAVIOUR
//   Format: [15:11] opcode, [10:8] rx, [7:5] ry, [7:0] imm. Opcodes: 00 NOP, 01 MOV rx<-ry, 02 LDI rx<-imm,
//     03 ADD, 04 SUB, 05 AND, 06 OR, 07 XOR (rx<-rx op ry), 08 CMP (SUB, flags only), 09 JMP, 0A JZ, 0B JN, 1F HALT.
//   Reset (async, any state): state=FETCH, pc=0, flags=0, IR=0, all strobes 0, data_sel=00, sels 0, halted=0, illegal_op=0.
//   FSM: FETCH -> DECODE -> EXECUTE -> WRITEBACK -> FETCH; EXECUTE -> FETCH for NOP/CMP/jumps; any -> HALT on 1F.
//   FETCH: instr_req=1; on clk edge with instr_valid=1 latch IR, pc<=pc+1 (wraps to 0), go DECODE; else stay.
//   DECODE: one cycle; rx_sel/ry_sel/alu_op/data_sel/imm_out driven from IR and held stable until next FETCH.
//   EXECUTE: ALU ops and CMP latch alu_flags_in into flag reg at cycle end; MOV asserts reg_read_en here and in WRITEBACK.
//     JMP: pc<=imm[PC_W-1:0]; JZ/JN: same when latched Z/N=1, else pc unchanged. Flags unaffected by non-ALU ops.
//   WRITEBACK: reg_write_en=1 for exactly one cycle (MOV, LDI, ADD..XOR); bank captures on that edge.
//   Latency: write ops 3 cycles after instr_valid edge to next instr_req; NOP/CMP/jumps 2 cycles; back-to-back
//     instr_valid with zero wait states yields one instruction per 4 (write) or 3 (other) cycles.
//   HALT: instr_req=0, all strobes 0, halted=1; exits only via rst_n.
//   reg_read_en and reg_write_en never assert outside MOV/WRITEBACK rules; never both set on a non-MOV op.
//   rx==ry legal (e.g. XOR r3,r3 writes 0). instr_valid while not in FETCH: ignored, no state change.
// CONFIGURATION
//   CU_ILLEGAL_TRAP_EN defined: unlisted opcode -> HALT, illegal_op=1 (sticky until reset).
//   Not defined: unlisted opcode executes as NOP; illegal_op tied 0.
// STRUCTURE
//   cu_pkg: opcode localparams, state encoding (FETCH/DECODE/EXECUTE/WRITEBACK/HALT), data_sel and alu_op codes,
//     flag bit indices.
//   Sub-module cu_decode: combinational opcode -> {is_write, is_alu, is_jump, is_cmp, data_sel, alu_op, legal}.
//   control_unit holds FSM, PC, IR, flag reg.
// TESTING
//   Reset mid-WRITEBACK of ADD -> next cycle FETCH, pc=0, reg_write_en=0, instr_req=1, flags=0.
//   LDI r4,0xAA with instr_valid on first FETCH cycle -> rx_sel=4, data_sel=01, imm_out=AA, reg_write_en one pulse
//     3 cycles later; pc=1.
//   MOV r0<-r4 -> ry_sel=4, reg_read_en high EXECUTE+WRITEBACK, data_sel=10, reg_write_en pulse with rx_sel=0.
//   CMP r1,r1 with alu_flags_in=4'b1000, then JZ 0x20 -> no write strobe, pc_out=0x20 at next FETCH.
//   JN 0x10 with latched N=0 -> pc continues sequentially; JMP 0xFF then NOP -> pc_out wraps 0xFF -> 0x00.
//   Opcode 0x1C: with CU_ILLEGAL_TRAP_EN -> halted=1, illegal_op=1, instr_req=0; without -> NOP, pc advances.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared encodings for the control unit: opcodes, FSM states, bank mux selects, ALU ops, flag bit positions.
package cu_pkg;

  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_MOV  = 5'h01;
  localparam logic [4:0] OP_LDI  = 5'h02;
  localparam logic [4:0] OP_ADD  = 5'h03;
  localparam logic [4:0] OP_SUB  = 5'h04;
  localparam logic [4:0] OP_AND  = 5'h05;
  localparam logic [4:0] OP_OR   = 5'h06;
  localparam logic [4:0] OP_XOR  = 5'h07;
  localparam logic [4:0] OP_CMP  = 5'h08;
  localparam logic [4:0] OP_JMP  = 5'h09;
  localparam logic [4:0] OP_JZ   = 5'h0A;
  localparam logic [4:0] OP_JN   = 5'h0B;
  localparam logic [4:0] OP_HALT = 5'h1F;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT} state_t;

  localparam logic [1:0] DSEL_ALU = 2'b00;
  localparam logic [1:0] DSEL_IMM = 2'b01;
  localparam logic [1:0] DSEL_BUS = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;

  // flag register layout is {Z,N,C,V}
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {J_ALWAYS, J_Z, J_N} jcond_t;

  typedef struct packed {
    logic       is_write;
    logic       is_alu;
    logic       is_jump;
    logic       is_cmp;
    logic       is_mov;
    logic       is_halt;
    logic       legal;
    jcond_t     jcond;
    logic [1:0] data_sel;
    logic [2:0] alu_op;
  } dec_t;

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode decoder; unlisted opcodes decode as a NOP with legal=0.
import cu_pkg::*;

module cu_decode (
  input  logic [4:0] opcode,
  output dec_t       dec
);

  always_comb begin
    dec          = '0;
    dec.jcond    = J_ALWAYS;
    dec.data_sel = DSEL_ALU;
    dec.alu_op   = ALU_ADD;
    dec.legal    = 1'b1;
    case (opcode)
      OP_NOP:  ;
      OP_MOV:  begin dec.is_write = 1'b1; dec.is_mov = 1'b1; dec.data_sel = DSEL_BUS; end
      OP_LDI:  begin dec.is_write = 1'b1; dec.data_sel = DSEL_IMM; end
      OP_ADD:  begin dec.is_write = 1'b1; dec.is_alu = 1'b1; dec.alu_op = ALU_ADD; end
      OP_SUB:  begin dec.is_write = 1'b1; dec.is_alu = 1'b1; dec.alu_op = ALU_SUB; end
      OP_AND:  begin dec.is_write = 1'b1; dec.is_alu = 1'b1; dec.alu_op = ALU_AND; end
      OP_OR:   begin dec.is_write = 1'b1; dec.is_alu = 1'b1; dec.alu_op = ALU_OR;  end
      OP_XOR:  begin dec.is_write = 1'b1; dec.is_alu = 1'b1; dec.alu_op = ALU_XOR; end
      OP_CMP:  begin dec.is_cmp = 1'b1; dec.alu_op = ALU_SUB; end
      OP_JMP:  begin dec.is_jump = 1'b1; dec.jcond = J_ALWAYS; end
      OP_JZ:   begin dec.is_jump = 1'b1; dec.jcond = J_Z; end
      OP_JN:   begin dec.is_jump = 1'b1; dec.jcond = J_N; end
      OP_HALT: dec.is_halt = 1'b1;
      default: dec.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute/writeback sequencer for the 8x8 register bank.
// Define CU_ILLEGAL_TRAP_EN to halt on unlisted opcodes and raise a sticky illegal_op.
import cu_pkg::*;

module control_unit #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               instr_req,
  output logic [PC_W-1:0]    pc_out,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [2:0]         rx_sel,
  output logic [2:0]         ry_sel,
  output logic               reg_read_en,
  output logic               reg_write_en,
  output logic [1:0]         data_sel,
  output logic [7:0]         imm_out,
  output logic [2:0]         alu_op,
  input  logic [3:0]         alu_flags_in,
  output logic               halted,
  output logic               illegal_op
);

  state_t             state;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] ir;
  logic [3:0]         flags;
  dec_t               dec;
  logic               trap;
  logic               take_jump;

  cu_decode u_dec (
    .opcode (ir[15:11]),
    .dec    (dec)
  );

`ifdef CU_ILLEGAL_TRAP_EN
  assign trap = ~dec.legal;
`else
  assign trap = 1'b0;
`endif

  // Field selects come straight from IR, so they stay stable from DECODE until the next fetch latches.
  assign rx_sel   = ir[10:8];
  assign ry_sel   = ir[7:5];
  assign imm_out  = ir[7:0];
  assign data_sel = dec.data_sel;
  assign alu_op   = dec.alu_op;
  assign pc_out   = pc;

  always_comb begin
    take_jump = 1'b0;
    if (dec.is_jump) begin
      case (dec.jcond)
        J_Z:     take_jump = flags[FLAG_Z];
        J_N:     take_jump = flags[FLAG_N];
        default: take_jump = 1'b1;
      endcase
    end
  end

`ifndef CU_ILLEGAL_TRAP_EN
  assign illegal_op = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_FETCH;
      pc           <= '0;
      ir           <= '0;
      flags        <= '0;
      instr_req    <= 1'b1;
      reg_read_en  <= 1'b0;
      reg_write_en <= 1'b0;
      halted       <= 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
      illegal_op   <= 1'b0;
`endif
    end else begin
      case (state)
        S_FETCH: if (instr_valid) begin
          ir        <= instr_in;
          pc        <= pc + PC_W'(1);
          instr_req <= 1'b0;
          state     <= S_DECODE;
        end
        S_DECODE: if (dec.is_halt || trap) begin
          halted <= 1'b1;
`ifdef CU_ILLEGAL_TRAP_EN
          if (trap) illegal_op <= 1'b1;
`endif
          state  <= S_HALT;
        end else begin
          reg_read_en <= dec.is_mov;
          state       <= S_EXECUTE;
        end
        S_EXECUTE: begin
          if (dec.is_alu || dec.is_cmp) flags <= alu_flags_in;
          if (take_jump) pc <= PC_W'(ir[7:0]);
          if (dec.is_write) begin
            reg_write_en <= 1'b1;
            state        <= S_WRITEBACK;
          end else begin
            reg_read_en <= 1'b0;
            instr_req   <= 1'b1;
            state       <= S_FETCH;
          end
        end
        S_WRITEBACK: begin
          reg_write_en <= 1'b0;
          reg_read_en  <= 1'b0;
          instr_req    <= 1'b1;
          state        <= S_FETCH;
        end
        S_HALT: ;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-instruction latency/strobe checks plus a write-strobe scoreboard.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_req;
  logic [7:0]  pc_out;
  logic        instr_valid = 1'b0;
  logic [15:0] instr_in = '0;
  logic [2:0]  rx_sel, ry_sel, alu_op;
  logic        reg_read_en, reg_write_en, halted, illegal_op;
  logic [1:0]  data_sel;
  logic [7:0]  imm_out;
  logic [3:0]  alu_flags_in = '0;

  control_unit #(.PC_W(8), .INSTR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .instr_req(instr_req), .pc_out(pc_out),
    .instr_valid(instr_valid), .instr_in(instr_in), .rx_sel(rx_sel), .ry_sel(ry_sel),
    .reg_read_en(reg_read_en), .reg_write_en(reg_write_en), .data_sel(data_sel),
    .imm_out(imm_out), .alu_op(alu_op), .alu_flags_in(alu_flags_in),
    .halted(halted), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  logic [7:0] mpc = '0;
  logic [3:0] mflags = '0;

  typedef struct packed {
    logic [2:0] rx;
    logic [2:0] ry;
    logic [1:0] dsel;
    logic [2:0] aop;
    logic [7:0] imm;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_o, mon_e;
  bit  sb_en = 1'b1;

  function automatic wr_t exp_wr(input logic [15:0] w);
    wr_t e;
    logic [4:0] op;
    op     = w[15:11];
    e.rx   = w[10:8];
    e.ry   = w[7:5];
    e.imm  = w[7:0];
    e.dsel = (op == 5'h01) ? 2'b10 : (op == 5'h02) ? 2'b01 : 2'b00;
    case (op)
      5'h04:   e.aop = 3'b001;
      5'h05:   e.aop = 3'b010;
      5'h06:   e.aop = 3'b011;
      5'h07:   e.aop = 3'b100;
      default: e.aop = 3'b000;
    endcase
    return e;
  endfunction

  // Every write strobe must match the oldest outstanding write instruction.
  always @(negedge clk) begin
    if (sb_en && rst_n && reg_write_en) begin
      mon_o = {rx_sel, ry_sel, data_sel, alu_op, imm_out};
      total++;
      if (exp_q.size() == 0) $display("FAIL sb_unexpected_write got=%h", mon_o);
      else begin
        mon_e = exp_q.pop_front();
        if (mon_o !== mon_e) $display("FAIL sb_write got=%h exp=%h", mon_o, mon_e);
        else passed++;
      end
    end
  end

  task automatic issue(input logic [15:0] w, input bit noisy);
    logic [4:0] op;
    int k, n, wr, rd, lat;
    bit legal, trap, hlt, is_wr;
    op    = w[15:11];
    legal = (op <= 5'h0B) || (op == 5'h1F);
`ifdef CU_ILLEGAL_TRAP_EN
    trap = !legal;
`else
    trap = 1'b0;
`endif
    hlt   = (op == 5'h1F) || trap;
    is_wr = (op >= 5'h01) && (op <= 5'h07);
    k = 0;
    while (!instr_req && k < 20) begin @(negedge clk); k++; end
    total++;
    if (instr_req !== 1'b1) $display("FAIL fetch_timeout op=%h instr_req=%b exp=1", op, instr_req);
    else passed++;
    total++;
    if (pc_out !== mpc) $display("FAIL fetch_pc op=%h got=%h exp=%h", op, pc_out, mpc);
    else passed++;
    instr_in = w;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    mpc = mpc + 8'd1;
    if (is_wr) exp_q.push_back(exp_wr(w));
    n = 0; wr = 0; rd = 0;
    do begin
      @(negedge clk);
      n++;
      wr += int'(reg_write_en);
      rd += int'(reg_read_en);
      if (noisy && n == 1) begin instr_valid = 1'b1; instr_in = 16'hF800; end
      if (n == 2) instr_valid = 1'b0;
    end while (!instr_req && !halted && n < 12);
    instr_valid = 1'b0;
    if (hlt) begin
      total++;
      if (!(halted === 1'b1 && instr_req === 1'b0 && reg_write_en === 1'b0 && reg_read_en === 1'b0))
        $display("FAIL halt_entry op=%h halted=%b req=%b we=%b re=%b exp=1000", op, halted, instr_req, reg_write_en, reg_read_en);
      else passed++;
    end else begin
      lat = is_wr ? 3 : 2;
      total++;
      if (n - 1 !== lat) $display("FAIL latency op=%h got=%0d exp=%0d", op, n - 1, lat);
      else passed++;
      total++;
      if (wr !== int'(is_wr)) $display("FAIL write_pulses op=%h got=%0d exp=%0d", op, wr, int'(is_wr));
      else passed++;
      total++;
      if (rd !== ((op == 5'h01) ? 2 : 0)) $display("FAIL read_cycles op=%h got=%0d exp=%0d", op, rd, (op == 5'h01) ? 2 : 0);
      else passed++;
      if (op >= 5'h03 && op <= 5'h08) mflags = alu_flags_in;
      if (op == 5'h09 || (op == 5'h0A && mflags[3]) || (op == 5'h0B && mflags[2])) mpc = w[7:0];
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mpc = '0;
    mflags = '0;
  endtask

  task automatic test_reset();
    alu_flags_in = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({instr_req, pc_out} !== {1'b1, 8'h00}) $display("FAIL reset_fetch got=%b/%h exp=1/00", instr_req, pc_out);
    else passed++;
    total++;
    if ({rx_sel, ry_sel, data_sel, alu_op, imm_out} !== 19'd0)
      $display("FAIL reset_sels got=%h exp=0", {rx_sel, ry_sel, data_sel, alu_op, imm_out});
    else passed++;
    total++;
    if ({reg_read_en, reg_write_en, halted, illegal_op} !== 4'b0000)
      $display("FAIL reset_strobes got=%b exp=0000", {reg_read_en, reg_write_en, halted, illegal_op});
    else passed++;
    rst_n = 1'b1;
    mpc = '0;
    mflags = '0;
  endtask

  task automatic test_ldi();
    issue({5'h02, 3'd4, 8'hAA}, 1'b0);
    total++;
    if (pc_out !== 8'h01) $display("FAIL ldi_pc got=%h exp=01", pc_out);
    else passed++;
  endtask

  task automatic test_mov();
    issue({5'h01, 3'd0, 3'd4, 5'd0}, 1'b0);
  endtask

  task automatic test_alu();
    alu_flags_in = 4'b0000;
    issue({5'h03, 3'd1, 3'd2, 5'd0}, 1'b0);
    issue({5'h04, 3'd2, 3'd3, 5'd0}, 1'b0);
    issue({5'h05, 3'd5, 3'd6, 5'd0}, 1'b0);
    issue({5'h06, 3'd7, 3'd0, 5'd0}, 1'b0);
    alu_flags_in = 4'b0100;
    issue({5'h07, 3'd3, 3'd3, 5'd0}, 1'b0);
    alu_flags_in = 4'b0000;
    issue({5'h0B, 3'd0, 8'h30}, 1'b0);
    issue({5'h00, 11'd0}, 1'b0);
  endtask

  task automatic test_cmp_jz();
    alu_flags_in = 4'b1000;
    issue({5'h08, 3'd1, 3'd1, 5'd0}, 1'b0);
    alu_flags_in = 4'b0000;
    issue({5'h0A, 3'd0, 8'h20}, 1'b0);
    total++;
    if (pc_out !== 8'h20) $display("FAIL jz_taken_pc got=%h exp=20", pc_out);
    else passed++;
    issue({5'h00, 11'd0}, 1'b0);
  endtask

  task automatic test_jn();
    alu_flags_in = 4'b0000;
    issue({5'h08, 3'd2, 3'd3, 5'd0}, 1'b0);
    alu_flags_in = 4'b0100;
    issue({5'h0B, 3'd0, 8'h10}, 1'b0);
    alu_flags_in = 4'b0000;
    issue({5'h00, 11'd0}, 1'b0);
  endtask

  task automatic test_wrap();
    issue({5'h09, 3'd0, 8'hFF}, 1'b0);
    issue({5'h00, 11'd0}, 1'b0);
    total++;
    if (pc_out !== 8'h00) $display("FAIL pc_wrap got=%h exp=00", pc_out);
    else passed++;
  endtask

  task automatic test_back_to_back();
    issue({5'h02, 3'd1, 8'h5C}, 1'b1);
    issue({5'h00, 11'd0}, 1'b1);
    issue({5'h01, 3'd6, 3'd1, 5'd0}, 1'b1);
    issue({5'h07, 3'd2, 3'd5, 5'd0}, 1'b0);
    total++;
    if (halted !== 1'b0) $display("FAIL ignore_valid_outside_fetch halted=%b exp=0", halted);
    else passed++;
  endtask

  task automatic test_reset_mid_wb();
    int k;
    alu_flags_in = 4'b1000;
    sb_en = 1'b0;
    k = 0;
    while (!instr_req && k < 20) begin @(negedge clk); k++; end
    instr_in = {5'h03, 3'd1, 3'd2, 5'd0};
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!reg_write_en && k < 10);
    total++;
    if (reg_write_en !== 1'b1) $display("FAIL mid_wb_reach we=%b exp=1", reg_write_en);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({reg_write_en, instr_req, pc_out} !== {1'b0, 1'b1, 8'h00})
      $display("FAIL mid_wb_async got=%b/%b/%h exp=0/1/00", reg_write_en, instr_req, pc_out);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    sb_en = 1'b1;
    mpc = '0;
    mflags = '0;
    alu_flags_in = 4'b0000;
    @(negedge clk);
    total++;
    if ({reg_write_en, instr_req, pc_out} !== {1'b0, 1'b1, 8'h00})
      $display("FAIL mid_wb_after got=%b/%b/%h exp=0/1/00", reg_write_en, instr_req, pc_out);
    else passed++;
    // Z was latched before the reset; a cleared flag register means JZ falls through
    issue({5'h0A, 3'd0, 8'h40}, 1'b0);
    issue({5'h00, 11'd0}, 1'b0);
  endtask

  task automatic test_illegal();
    issue({5'h1C, 11'd0}, 1'b0);
    repeat (3) @(negedge clk);
`ifdef CU_ILLEGAL_TRAP_EN
    total++;
    if ({halted, illegal_op, instr_req} !== 3'b110)
      $display("FAIL illegal_trap got=%b exp=110", {halted, illegal_op, instr_req});
    else passed++;
    do_reset();
`else
    total++;
    if ({halted, illegal_op, instr_req, pc_out} !== {3'b001, mpc})
      $display("FAIL illegal_nop got=%b/%h exp=001/%h", {halted, illegal_op, instr_req}, pc_out, mpc);
    else passed++;
`endif
  endtask

  task automatic test_halt();
    int bad;
    issue({5'h1F, 11'd0}, 1'b0);
    bad = 0;
    instr_in = {5'h02, 3'd2, 8'h11};
    instr_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!(halted === 1'b1 && instr_req === 1'b0 && reg_write_en === 1'b0 && reg_read_en === 1'b0)) bad++;
    end
    instr_valid = 1'b0;
    total++;
    if (bad !== 0) $display("FAIL halt_sticky bad_cycles=%0d exp=0", bad);
    else passed++;
    total++;
    if (illegal_op !== 1'b0) $display("FAIL halt_illegal got=%b exp=0", illegal_op);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_mov();
    test_alu();
    test_cmp_jz();
    test_jn();
    test_wrap();
    test_back_to_back();
    test_reset_mid_wb();
    test_illegal();
    test_halt();
    repeat (2) @(negedge clk);
    total++;
    if (exp_q.size() !== 0) $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", passed, total);
    $fatal(1);
  end

endmodule
